// File: rtl/uart_tx_core_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_core_pkg
// Brief   : Shared constants, line levels and FSM state type for the 8N1 TX core.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package uart_tx_core_pkg;

  localparam int BAUD_RATE_DEFAULT = 20;
  localparam int FRAME_BITS        = 10;
  localparam int DATA_BITS         = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_core_if.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_core_if
// Brief   : Parallel request side and serial/tick outputs of the UART TX core.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_core_if;
  import uart_tx_core_pkg::*;

  logic                 start;
  logic [DATA_BITS-1:0] data;
  logic                 baud_rate_signal;
  logic                 uart_tx;

  modport master (
    output start,
    output data,
    input  baud_rate_signal,
    input  uart_tx
  );

  modport slave (
    input  start,
    input  data,
    output baud_rate_signal,
    output uart_tx
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
//------------------------------------------------------------------------------
// Module  : uart_baud_tick
// Brief   : Free-running modulo-N counter with a registered one-clock tick.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_baud_tick
  import uart_tx_core_pkg::*;
#(
  parameter int BAUD_RATE_NUMBER = BAUD_RATE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int              CNT_W    = (BAUD_RATE_NUMBER > 2) ? $clog2(BAUD_RATE_NUMBER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_RATE_NUMBER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CNT_LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_core.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_core
// Brief   : 8N1 UART transmitter: baud tick generator plus tick-paced serializer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int BAUD_RATE_NUMBER = BAUD_RATE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_core_if.slave  bus
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic                 baud_tick;
  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q,   idx_d;
  logic                 tx_q,    tx_d;

  uart_baud_tick #(
    .BAUD_RATE_NUMBER (BAUD_RATE_NUMBER)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (baud_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_d = bus.data;
            tx_d    = START_BIT;
            state_d = START;
          end else begin
            tx_d = IDLE_LEVEL;
          end
        end
        START: begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (idx_q != LAST_IDX) begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + 3'd1;
          end else begin
            tx_d    = STOP_BIT;
            state_d = STOP;
          end
        end
        STOP: begin
          // Extra high interval: a new frame may only start on the next tick.
          tx_d    = IDLE_LEVEL;
          state_d = IDLE;
        end
        default: begin
          tx_d    = IDLE_LEVEL;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.uart_tx          = tx_q;
  assign bus.baud_rate_signal = baud_tick;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_core.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_tx_core
// Brief   : Self-checking bench for uart_tx_core against a frame-level line model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_core;
  import uart_tx_core_pkg::*;

  localparam int N = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_core_if bus ();

  uart_tx_core #(
    .BAUD_RATE_NUMBER (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Line model: a tick every N clocks; a started frame queues d0..d7, stop and one guard high.
  int         m_edges;
  logic       m_tick;
  logic       m_tx;
  logic [9:0] m_rest;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_tick  <= 1'b0;
      m_tx    <= 1'b1;
      m_rest  <= '0;
      m_left  <= 0;
    end else begin
      m_edges <= m_edges + 1;
      m_tick  <= (((m_edges + 1) % N) == 0);
      if (m_tick) begin
        if (m_left > 0) begin
          m_tx   <= m_rest[0];
          m_rest <= m_rest >> 1;
          m_left <= m_left - 1;
        end else if (bus.start) begin
          m_tx   <= 1'b0;
          m_rest <= {2'b11, bus.data};
          m_left <= 10;
        end else begin
          m_tx <= 1'b1;
        end
      end
    end
  end

  function automatic logic exp_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return d[j-1];
  endfunction

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (bus.baud_rate_signal === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: no baud tick within %0d clocks, required one", 3 * N);
    end
  endtask

  // Returns the line level one clock after the next tick.
  task automatic sample_bit(output logic v);
    bit ok;
    wait_tick(ok);
    @(negedge clk);
    v = bus.uart_tx;
  endtask

  task automatic test_reset();
    int first = 0;
    int ticks = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.data  = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.uart_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_tx: uart_tx=%b required 1", bus.uart_tx);
    end
    vectors++;
    if (bus.baud_rate_signal !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tick: baud_rate_signal=%b required 0", bus.baud_rate_signal);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 100 * N; i++) begin
      @(negedge clk);
      if (bus.baud_rate_signal === 1'b1) begin
        ticks++;
        if (first == 0) first = i;
      end
      vectors++;
      if (bus.baud_rate_signal !== m_tick) begin
        miscompares++;
        $display("FAIL idle_tick@%0d: baud_rate_signal=%b required %b", i, bus.baud_rate_signal, m_tick);
      end
      vectors++;
      if (bus.uart_tx !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_tx@%0d: uart_tx=%b required 1", i, bus.uart_tx);
      end
    end
    vectors++;
    if (first != N) begin
      miscompares++;
      $display("FAIL first_tick: first tick at clock %0d required %0d", first, N);
    end
    vectors++;
    if (ticks != 100) begin
      miscompares++;
      $display("FAIL tick_count: %0d ticks required 100", ticks);
    end
    @(negedge clk);
  endtask

  task automatic test_frame_a5();
    logic v;
    bus.data  = 8'hA5;
    bus.start = 1'b1;
    for (int j = 0; j < 10; j++) begin
      sample_bit(v);
      vectors++;
      if (v !== exp_bit(8'hA5, j)) begin
        miscompares++;
        $display("FAIL a5_bit%0d: uart_tx=%b required %b", j, v, exp_bit(8'hA5, j));
      end
      vectors++;
      if (v !== m_tx) begin
        miscompares++;
        $display("FAIL a5_model%0d: uart_tx=%b model %b", j, v, m_tx);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic v;
    @(negedge clk);
    bus.data = 8'h3C;
    sample_bit(v);
    vectors++;
    if (v !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_guard: uart_tx=%b required 1", v);
    end
    for (int j = 0; j < 10; j++) begin
      sample_bit(v);
      vectors++;
      if (v !== exp_bit(8'h3C, j)) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: uart_tx=%b required %b", j, v, exp_bit(8'h3C, j));
      end
      vectors++;
      if (v !== m_tx) begin
        miscompares++;
        $display("FAIL b2b_model%0d: uart_tx=%b model %b", j, v, m_tx);
      end
    end
  endtask

  task automatic test_data_change();
    logic v;
    bus.data = 8'h00;
    sample_bit(v);
    vectors++;
    if (v !== 1'b1) begin
      miscompares++;
      $display("FAIL dchg_guard: uart_tx=%b required 1", v);
    end
    for (int j = 0; j < 10; j++) begin
      sample_bit(v);
      if (j == 0) bus.data = 8'hFF;
      vectors++;
      if (v !== exp_bit(8'h00, j)) begin
        miscompares++;
        $display("FAIL dchg_bit%0d: uart_tx=%b required %b", j, v, exp_bit(8'h00, j));
      end
    end
  endtask

  task automatic test_drop_start();
    logic       v;
    logic [7:0] d;
    d        = 8'($urandom);
    bus.data = d;
    sample_bit(v);
    vectors++;
    if (v !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_guard: uart_tx=%b required 1", v);
    end
    for (int j = 0; j < 10; j++) begin
      sample_bit(v);
      if (j == 4) bus.start = 1'b0;
      vectors++;
      if (v !== exp_bit(d, j)) begin
        miscompares++;
        $display("FAIL drop_bit%0d: uart_tx=%b required %b (data %h)", j, v, exp_bit(d, j), d);
      end
    end
    for (int t = 0; t < 15; t++) begin
      sample_bit(v);
      vectors++;
      if (v !== 1'b1) begin
        miscompares++;
        $display("FAIL drop_idle%0d: uart_tx=%b required 1", t, v);
      end
      vectors++;
      if (v !== m_tx) begin
        miscompares++;
        $display("FAIL drop_model%0d: uart_tx=%b model %b", t, v, m_tx);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic       v;
    logic [7:0] d;
    int         first = 0;
    d         = 8'($urandom);
    bus.data  = d;
    bus.start = 1'b1;
    for (int j = 0; j < 6; j++) sample_bit(v);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.uart_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_tx: uart_tx=%b required 1", bus.uart_tx);
    end
    vectors++;
    if (bus.baud_rate_signal !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_tick: baud_rate_signal=%b required 0", bus.baud_rate_signal);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3 * N; i++) begin
      @(negedge clk);
      if (bus.baud_rate_signal === 1'b1) begin
        first = i;
        break;
      end
    end
    vectors++;
    if (first != N) begin
      miscompares++;
      $display("FAIL midrst_first_tick: first tick at clock %0d required %0d", first, N);
    end
    @(negedge clk);
    vectors++;
    if (bus.uart_tx !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_start: uart_tx=%b required 0", bus.uart_tx);
    end
    for (int j = 1; j < 10; j++) begin
      sample_bit(v);
      vectors++;
      if (v !== exp_bit(d, j)) begin
        miscompares++;
        $display("FAIL midrst_bit%0d: uart_tx=%b required %b (data %h)", j, v, exp_bit(d, j), d);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] perm [256];
    logic [7:0] tmp;
    logic       v;
    int         r;
    for (int k = 0; k < 256; k++) perm[k] = 8'(k);
    for (int k = 255; k > 0; k--) begin
      r       = int'($urandom_range(k, 0));
      tmp     = perm[k];
      perm[k] = perm[r];
      perm[r] = tmp;
    end
    bus.start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      bus.data = perm[k];
      sample_bit(v);
      vectors++;
      if (v !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_guard %h: uart_tx=%b required 1", perm[k], v);
      end
      for (int j = 0; j < 10; j++) begin
        sample_bit(v);
        vectors++;
        if (v !== exp_bit(perm[k], j)) begin
          miscompares++;
          $display("FAIL sweep %h bit%0d: uart_tx=%b required %b", perm[k], j, v, exp_bit(perm[k], j));
        end
        vectors++;
        if (v !== m_tx) begin
          miscompares++;
          $display("FAIL sweep_model %h bit%0d: uart_tx=%b model %b", perm[k], j, v, m_tx);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_data_change();
    test_drop_start();
    test_reset_mid_frame();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
